nonce_search_ctrl: RTL

//  Sequencer directly upstream of the micro_ucr_hash datapath. Takes a 96-bit block header
//  and an 8-bit target, then sweeps a 32-bit nonce. Issues {bloque_datos, nonce} to the hash

---
 rtl/nonce_search_ctrl.sv | 91 +++++++++
 1 files changed

// File: rtl/nonce_search_ctrl.sv
// nonce_search_ctrl: sweeps a 32-bit nonce over a latched header, issues each candidate to the hash stage and stops on the first hash under target or on exhaustion/timeout
//   in  clk, reset (async, active-high), start, bloque_datos[95:0], target[7:0], hash_H[23:0], hash_ok
//   out hash_bloque[127:0] = {header, nonce}, hash_req, busy, terminado, found, timeout, bounty[55:0] = {nonce, H}
//   NONCE_SEARCH_STATS_EN adds out intentos[31:0]: hash_req pulses since the last accepted start
module nonce_search_ctrl #(
   parameter logic [31:0] NONCE_START = 32'h0000_0000,
   parameter logic [31:0] NONCE_LAST  = 32'hFFFF_FFFF,
   parameter int unsigned MAX_WAIT    = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [95:0]  bloque_datos,
   input  logic [7:0]   target,
   output logic [127:0] hash_bloque,
   output logic         hash_req,
   input  logic [23:0]  hash_H,
   input  logic         hash_ok,
   output logic         busy,
   output logic         terminado,
   output logic         found,
   output logic         timeout,
`ifdef NONCE_SEARCH_STATS_EN
   output logic [31:0]  intentos,
`endif
   output logic [55:0]  bounty
);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, DONE} state_t;
   state_t state, state_nx;
   logic [95:0] hdr;
   logic [7:0]  tgt;
   logic [31:0] nonce;
   logic [23:0] h;
   logic [15:0] wcnt;
   logic        go, hit, expired;
   assign go          = start && (state == IDLE || state == DONE);
   assign hit         = (h[23:16] < tgt) && (h[15:8] < tgt);
   // last WAIT cycle; a hash_ok arriving here still wins over the timeout
   assign expired     = wcnt == 16'(MAX_WAIT - 1);
   assign hash_bloque = {hdr, nonce};
   assign hash_req    = state == ISSUE;
   assign busy        = state == ISSUE || state == WAIT || state == CHECK;
   assign terminado   = state == DONE;
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: state_nx = go ? ISSUE : state;
         ISSUE:      state_nx = WAIT;
         WAIT:       state_nx = hash_ok ? CHECK : expired ? DONE : WAIT;
         CHECK:      state_nx = (hit || nonce == NONCE_LAST) ? DONE : ISSUE;
         default:    state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         hdr     <= '0;
         tgt     <= '0;
         nonce   <= NONCE_START;
         h       <= '0;
         wcnt    <= '0;
         found   <= 1'b0;
         timeout <= 1'b0;
         bounty  <= '0;
      end else begin
         wcnt <= (state == WAIT) ? wcnt + 16'd1 : 16'd0;
         if (go) begin
            hdr     <= bloque_datos;
            tgt     <= target;
            nonce   <= NONCE_START;
            found   <= 1'b0;
            timeout <= 1'b0;
            bounty  <= '0;
         end
         if (state == WAIT && hash_ok) h <= hash_H;
         if (state == WAIT && !hash_ok && expired) timeout <= 1'b1;
         if (state == CHECK && hit) begin
            found  <= 1'b1;
            bounty <= {nonce, h};
         end
         if (state == CHECK && !hit && nonce != NONCE_LAST) nonce <= nonce + 32'd1;
      end
`ifdef NONCE_SEARCH_STATS_EN
   always_ff @(posedge clk or posedge reset)
      if (reset) intentos <= '0;
      else if (go) intentos <= '0;
      else if (hash_req && intentos != 32'hFFFF_FFFF) intentos <= intentos + 32'd1;
`endif
endmodule
